pipeline_ctrl: RTL
==================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter DRAIN_CYCLES, default 2, SHALL be the number of bubble cycles inserted after a syscall enters E before the OS handler is requested.
REQ-002 clk  in  1  SHALL be the single clock; all state updates on posedge clk.
REQ-003 reset  in  1  SHALL be a synchronous, active-high reset.
REQ-004 RsD, RtD  in  5  SHALL be the decode-stage source register numbers.
REQ-005 RsE, RtE  in  5  SHALL be the execute-stage source register numbers.
REQ-006 WriteRegE, WriteRegM, WriteRegW  in  5 each  SHALL be the destination registers in E, M and W.
REQ-007 RegWriteE, RegWriteM, RegWriteW  in  1 each  SHALL be the write enables in E, M and W.
REQ-008 MemtoRegE, MemtoRegM  in  1 each  SHALL flag loads in E and M.
REQ-009 BranchD, syscallD  in  1 each  SHALL flag a branch or syscall in D.
REQ-010 sys_done  in  1  SHALL be the handler-complete acknowledge.
REQ-011 StallF, StallD, FlushE  out  1 each  SHALL hold F, hold D, and zero the D-to-E register.
REQ-012 ForwardAE, ForwardBE  out  2 each  SHALL be the E-operand mux selects: 00 = register file, 01 = W result, 10 = M ALU result.
REQ-013 ForwardAD, ForwardBD  out  1 each  SHALL select the M ALU result for the D-stage branch comparator.
REQ-014 sys_req  out  1  SHALL request OS syscall service.

Function
REQ-015 Register 0 SHALL never match for forwarding or hazard detection.
REQ-016 ForwardAE SHALL be 10 when RsE==WriteRegM and RegWriteM are both true, else 01 when RsE==WriteRegW and RegWriteW are both true, else 00; M SHALL take priority over W. ForwardBE SHALL use the same rule with RtE.
REQ-017 ForwardAD SHALL be 1 when RsD==WriteRegM and RegWriteM are both true; ForwardBD SHALL be 1 under the same condition with RtD.
REQ-018 lwstall SHALL be MemtoRegE AND (RtE==RsD OR RtE==RtD).
REQ-019 branchstall SHALL be BranchD AND ((RegWriteE AND WriteRegE in {RsD,RtD}) OR (MemtoRegM AND WriteRegM in {RsD,RtD})).
REQ-020 Hazard stall SHALL be lwstall OR branchstall, asserting StallF, StallD and FlushE combinationally in the same cycle, with zero latency.
REQ-021 The syscall FSM SHALL have the states IDLE, DRAIN and REQ.
REQ-022 In IDLE, the FSM SHALL move to DRAIN at the next edge when syscallD=1 and hazard stall=0, loading drain_cnt=DRAIN_CYCLES.
REQ-023 In DRAIN, the block SHALL assert StallF, StallD and FlushE and decrement drain_cnt each cycle; when drain_cnt reaches 1 the FSM SHALL move to REQ.
REQ-024 In REQ, the block SHALL assert sys_req, StallF, StallD and FlushE until sys_done=1, then move to IDLE; all stalls SHALL release in the cycle after sys_done is sampled.
REQ-025 sys_done SHALL be ignored in IDLE and DRAIN.
REQ-026 syscallD=1 coinciding with hazard stall=1 SHALL remain in IDLE until the hazard clears.
REQ-027 sys_done and syscallD arriving in the same REQ cycle SHALL return the FSM to IDLE; the new syscall SHALL be accepted at the following edge.
REQ-028 Final stall outputs SHALL be the OR of the hazard stall and the FSM stall.

Reset
REQ-029 On reset=1 at posedge clk, the FSM SHALL enter IDLE, drain_cnt SHALL clear to 0 and sys_req SHALL be 0, including when reset occurs mid-DRAIN or mid-REQ.
REQ-030 While in IDLE, the combinational outputs SHALL follow REQ-016 to REQ-020 only.

Configuration
REQ-031 Macro PIPE_FORWARD_EN defined SHALL give the forwarding behaviour of REQ-016 and REQ-017.
REQ-032 With PIPE_FORWARD_EN undefined, all Forward* outputs SHALL be tied to 0, and hazard stall SHALL additionally assert whenever RsE or RtE, or RsD or RtD, equals WriteRegE (with RegWriteE) or WriteRegM (with RegWriteM).

Structure
REQ-033 Shared package pipe_ctrl_pkg SHALL hold the FSM state enum and the constants FWD_NONE=00, FWD_WB=01 and FWD_MEM=10.
REQ-034 The FSM and drain_cnt SHALL live in one sub-module, syscall_seq; hazard and forward logic SHALL remain in the top level.

Verification
REQ-035 RsE=5, WriteRegM=5, RegWriteM=1, WriteRegW=5, RegWriteW=1 -> ForwardAE=10; with RegWriteM=0 -> ForwardAE=01.
REQ-036 MemtoRegE=1, RtE=8, RsD=8 -> StallF=StallD=FlushE=1 in the same cycle; with RsD=0 and RtE=0 -> no stall.
REQ-037 syscallD=1 in IDLE -> exactly 2 DRAIN cycles, then sys_req=1 held; sys_done pulsed on cycle 6 -> sys_req=0 and stalls released on cycle 7.
REQ-038 reset=1 during REQ -> next cycle sys_req=0, StallF=0, FSM=IDLE.
REQ-039 BranchD=1, RsD=3, WriteRegE=3, RegWriteE=1 -> stall asserted; next cycle, with the producer now in M (non-load) -> stall=0 and ForwardAD=1.
REQ-040 With PIPE_FORWARD_EN undefined: RsD=4, WriteRegM=4, RegWriteM=1 -> stall=1 and all Forward*=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared syscall FSM states, forward-select codes and register-match helper.
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, DRAIN, REQ} sys_state_t;
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  // Register 0 is hardwired, so it never creates a dependency.
  function automatic logic hit(input logic [4:0] a, input logic [4:0] b, input logic en);
    return en && (a != 5'd0) && (a == b);
  endfunction
endpackage

// File: rtl/syscall_seq.sv
// syscall_seq: syscall drain/request sequencer that stalls the pipeline until the OS handler acknowledges.
module syscall_seq #(
  parameter int DRAIN_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic sys_done,
  output logic stall,
  output logic sys_req
);
  import pipe_ctrl_pkg::*;
  localparam int CW = $clog2(DRAIN_CYCLES + 1);
  sys_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    unique case (state)
      IDLE: begin
        state_n = start ? DRAIN : IDLE;
        cnt_n = start ? CW'(DRAIN_CYCLES) : cnt;
      end
      DRAIN: begin
        cnt_n = cnt - CW'(1);
        state_n = (cnt <= CW'(1)) ? REQ : DRAIN;
      end
      REQ: state_n = sys_done ? IDLE : REQ;
      default: state_n = IDLE;
    endcase
  end
  assign stall = state != IDLE;
  assign sys_req = state == REQ;
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard detection, operand forwarding and syscall stall control.
// Define PIPE_FORWARD_EN to enable forwarding; otherwise every E/M dependency stalls.
module pipeline_ctrl #(
  parameter int DRAIN_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic [4:0] RsE,
  input  logic [4:0] RtE,
  input  logic [4:0] WriteRegE,
  input  logic [4:0] WriteRegM,
  input  logic [4:0] WriteRegW,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       MemtoRegM,
  input  logic       BranchD,
  input  logic       syscallD,
  input  logic       sys_done,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       ForwardAD,
  output logic       ForwardBD,
  output logic       sys_req
);
  import pipe_ctrl_pkg::*;
  logic lwstall, branchstall, depstall, hazard, seq_stall;
  assign lwstall = MemtoRegE && (RtE != 5'd0) && (RtE == RsD || RtE == RtD);
  assign branchstall = BranchD && (hit(RsD, WriteRegE, RegWriteE) || hit(RtD, WriteRegE, RegWriteE) ||
                                   hit(RsD, WriteRegM, MemtoRegM) || hit(RtD, WriteRegM, MemtoRegM));
`ifdef PIPE_FORWARD_EN
  assign ForwardAE = hit(RsE, WriteRegM, RegWriteM) ? FWD_MEM : hit(RsE, WriteRegW, RegWriteW) ? FWD_WB : FWD_NONE;
  assign ForwardBE = hit(RtE, WriteRegM, RegWriteM) ? FWD_MEM : hit(RtE, WriteRegW, RegWriteW) ? FWD_WB : FWD_NONE;
  assign ForwardAD = hit(RsD, WriteRegM, RegWriteM);
  assign ForwardBD = hit(RtD, WriteRegM, RegWriteM);
  assign depstall = 1'b0;
`else
  logic unused_w;
  assign unused_w = ^{WriteRegW, RegWriteW};
  assign ForwardAE = FWD_NONE;
  assign ForwardBE = FWD_NONE;
  assign ForwardAD = 1'b0;
  assign ForwardBD = 1'b0;
  // Without bypass paths any in-flight producer in E or M must drain first.
  assign depstall = hit(RsE, WriteRegE, RegWriteE) || hit(RtE, WriteRegE, RegWriteE) ||
                    hit(RsD, WriteRegE, RegWriteE) || hit(RtD, WriteRegE, RegWriteE) ||
                    hit(RsE, WriteRegM, RegWriteM) || hit(RtE, WriteRegM, RegWriteM) ||
                    hit(RsD, WriteRegM, RegWriteM) || hit(RtD, WriteRegM, RegWriteM);
`endif
  assign hazard = lwstall || branchstall || depstall;
  syscall_seq #(.DRAIN_CYCLES(DRAIN_CYCLES)) u_seq (
    .clk(clk),
    .reset(reset),
    .start(syscallD && !hazard),
    .sys_done(sys_done),
    .stall(seq_stall),
    .sys_req(sys_req)
  );
  assign StallF = hazard || seq_stall;
  assign StallD = hazard || seq_stall;
  assign FlushE = hazard || seq_stall;
endmodule
